// File: rtl/cfu_mac_pipe_if.sv
// CFU command/response port for cfu_mac_pipe.
// The CPU side is the master: it offers commands and takes responses.
// The function unit is the slave: it accepts commands and returns one response per command.
interface cfu_mac_pipe_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_payload_function_id;
   logic [31:0] cmd_payload_inputs_0;
   logic [31:0] cmd_payload_inputs_1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_payload_outputs_0;

   modport master (
      output cmd_valid,
      output cmd_payload_function_id,
      output cmd_payload_inputs_0,
      output cmd_payload_inputs_1,
      output rsp_ready,
      input  cmd_ready,
      input  rsp_valid,
      input  rsp_payload_outputs_0
   );

   modport slave (
      input  cmd_valid,
      input  cmd_payload_function_id,
      input  cmd_payload_inputs_0,
      input  cmd_payload_inputs_1,
      input  rsp_ready,
      output cmd_ready,
      output rsp_valid,
      output rsp_payload_outputs_0
   );
endinterface

// File: rtl/cfu_mac_pipe.sv
// Pipelined 4-lane int8 SIMD MAC function unit with a bank of selectable
// 32-bit accumulators. S1 holds the lane products and the resolved command;
// S2 is the response register, and the accumulator bank is written on the
// S1->S2 transfer so back-to-back commands chain without hazards.
module cfu_mac_pipe #(
   parameter int NUM_ACC = 4,
   parameter bit SAT     = 1'b0
) (
   input  logic          clk,
   input  logic          reset,
   cfu_mac_pipe_if.slave bus
);

   localparam int IDX_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

   // Internal command classes carried through S1
   localparam logic [2:0] OP_MAC  = 3'd0;
   localparam logic [2:0] OP_SET  = 3'd1;
   localparam logic [2:0] OP_SEL  = 3'd2;
   localparam logic [2:0] OP_LOAD = 3'd3;
   localparam logic [2:0] OP_NOP  = 3'd4;

   // Architectural state
   logic signed [15:0] in_off;
   logic signed [15:0] flt_off;
   logic [IDX_W-1:0]   sel;
   logic [31:0]        acc [NUM_ACC];

   // Stage 1 registers
   logic               s1_valid;
   logic [2:0]         s1_op;
   logic [IDX_W-1:0]   s1_idx;
   logic [31:0]        s1_b;
   logic signed [33:0] s1_prod [4];

   // Stage 2 (response) registers
   logic               rsp_valid;
   logic [31:0]        rsp_data;

   // Handshake and datapath nets
   logic               s2_adv;
   logic               s1_adv;
   logic               cmd_ready;
   logic               accept;
   logic               s2_load;
   logic [6:0]         opcode;
   logic [2:0]         cmd_op;
   logic [IDX_W-1:0]   cmd_idx;
   logic signed [16:0] a_term [4];
   logic signed [16:0] b_term [4];
   logic signed [33:0] lane_prod [4];
   logic signed [35:0] lane_sum;
   logic signed [36:0] wide_sum;
   logic [31:0]        acc_cur;
   logic [31:0]        mac_result;
   logic [31:0]        s2_result;
   logic               unused_fid;

   // The low function_id bits carry no meaning for this unit
   assign unused_fid = ^bus.cmd_payload_function_id[2:0];

   // Pipeline flow control: S2 moves when empty or drained, S1 moves with S2
   assign s2_adv    = !rsp_valid || bus.rsp_ready;
   assign s1_adv    = s2_adv;
   assign cmd_ready = !s1_valid || s1_adv;
   assign accept    = bus.cmd_valid && cmd_ready;
   assign s2_load   = s1_valid && s2_adv;

   assign bus.cmd_ready             = cmd_ready;
   assign bus.rsp_valid             = rsp_valid;
   assign bus.rsp_payload_outputs_0 = rsp_data;

   // Decode the 7-bit opcode into the internal command class
   always_comb begin
      opcode = bus.cmd_payload_function_id[9:3];
      case (opcode)
         7'd0:    cmd_op = OP_MAC;
         7'd1:    cmd_op = OP_SET;
         7'd2:    cmd_op = OP_SEL;
         7'd3:    cmd_op = OP_LOAD;
         default: cmd_op = OP_NOP;
      endcase
   end

   // Resolve the target accumulator at accept so S1 never looks back at sel
   always_comb begin
      cmd_idx = sel;
      if (cmd_op == OP_SEL || cmd_op == OP_LOAD) begin
         cmd_idx = bus.cmd_payload_inputs_0[IDX_W-1:0];
      end
      if (NUM_ACC == 1) begin
         cmd_idx = '0;
      end
   end

   // Offset the int8 lanes and form full-precision signed lane products
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         a_term[i] = {{9{bus.cmd_payload_inputs_0[8*i+7]}}, bus.cmd_payload_inputs_0[8*i +: 8]}
                     + {in_off[15], in_off};
         b_term[i] = {{9{bus.cmd_payload_inputs_1[8*i+7]}}, bus.cmd_payload_inputs_1[8*i +: 8]}
                     + {flt_off[15], flt_off};
         lane_prod[i] = $signed({{17{a_term[i][16]}}, a_term[i]})
                        * $signed({{17{b_term[i][16]}}, b_term[i]});
      end
   end

   // Offsets and selection take effect at accept so the next command sees them
   always_ff @(posedge clk) begin
      if (reset) begin
         in_off  <= '0;
         flt_off <= '0;
         sel     <= '0;
      end else if (accept) begin
         if (cmd_op == OP_SET) begin
            in_off  <= bus.cmd_payload_inputs_0[15:0];
            flt_off <= bus.cmd_payload_inputs_1[15:0];
         end
         if (cmd_op == OP_SEL) begin
            sel <= cmd_idx;
         end
      end
   end

   // Stage 1 captures the products and resolved command, holding while S2 stalls
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_op    <= OP_NOP;
         s1_idx   <= '0;
         s1_b     <= '0;
         for (int i = 0; i < 4; i++) begin
            s1_prod[i] <= '0;
         end
      end else if (cmd_ready) begin
         s1_valid <= bus.cmd_valid;
         if (bus.cmd_valid) begin
            s1_op  <= cmd_op;
            s1_idx <= cmd_idx;
            s1_b   <= bus.cmd_payload_inputs_1;
            for (int i = 0; i < 4; i++) begin
               s1_prod[i] <= lane_prod[i];
            end
         end
      end
   end

   // Reduce the lanes and add to the live accumulator, wrapping or clamping
   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < 4; i++) begin
         lane_sum = lane_sum + {{2{s1_prod[i][33]}}, s1_prod[i]};
      end
      acc_cur  = acc[s1_idx];
      wide_sum = {{5{acc_cur[31]}}, acc_cur} + {lane_sum[35], lane_sum};
      if (SAT && (wide_sum[36:31] != {6{wide_sum[31]}})) begin
         mac_result = wide_sum[36] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
         mac_result = wide_sum[31:0];
      end
   end

   // Pick the response value for the command leaving S1
   always_comb begin
      case (s1_op)
         OP_MAC:  s2_result = mac_result;
         OP_SEL:  s2_result = acc_cur;
         OP_LOAD: s2_result = acc_cur;
         default: s2_result = '0;
      endcase
   end

   // Accumulator bank is written in command order on the S1->S2 transfer
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_ACC; i++) begin
            acc[i] <= '0;
         end
      end else if (s2_load) begin
         case (s1_op)
            OP_SET: begin
               for (int i = 0; i < NUM_ACC; i++) begin
                  acc[i] <= '0;
               end
            end
            OP_MAC:  acc[s1_idx] <= mac_result;
            OP_LOAD: acc[s1_idx] <= s1_b;
            default: ;
         endcase
      end
   end

   // Response register holds its payload until the CPU takes it
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else if (s2_adv) begin
         rsp_valid <= s1_valid;
         if (s1_valid) begin
            rsp_data <= s2_result;
         end
      end
   end

endmodule

// File: tb/tb_cfu_mac_pipe.sv
// Directed bench for cfu_mac_pipe: a wrapping instance and a saturating
// instance receive identical commands; each test task checks its own results.
module tb_cfu_mac_pipe;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [9:0]  fid       = '0;
   logic [31:0] op_a      = '0;
   logic [31:0] op_b      = '0;
   logic        rsp_ready = 1'b1;

   int total     = 0;
   int bad       = 0;
   int cyc       = 0;
   int stall_cnt = 0;
   int unstable  = 0;

   logic        hold_prev = 1'b0;
   logic [31:0] held      = '0;

   int          acc_cyc [$];
   int          rsp_cyc [$];
   logic [31:0] rsp_w   [$];
   logic [31:0] rsp_s   [$];

   // Free-running clock
   always #5 clk = ~clk;

   cfu_mac_pipe_if bus_w ();
   cfu_mac_pipe_if bus_s ();

   assign bus_w.cmd_valid               = cmd_valid;
   assign bus_w.cmd_payload_function_id = fid;
   assign bus_w.cmd_payload_inputs_0    = op_a;
   assign bus_w.cmd_payload_inputs_1    = op_b;
   assign bus_w.rsp_ready               = rsp_ready;
   assign bus_s.cmd_valid               = cmd_valid;
   assign bus_s.cmd_payload_function_id = fid;
   assign bus_s.cmd_payload_inputs_0    = op_a;
   assign bus_s.cmd_payload_inputs_1    = op_b;
   assign bus_s.rsp_ready               = rsp_ready;

   cfu_mac_pipe #(.NUM_ACC(4), .SAT(1'b0)) dut_w (.clk(clk), .reset(reset), .bus(bus_w));
   cfu_mac_pipe #(.NUM_ACC(4), .SAT(1'b1)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));

   // Record handshakes as seen just before each rising edge
   always @(posedge clk) begin
      if (!reset) begin
         if (cmd_valid && bus_w.cmd_ready) acc_cyc.push_back(cyc);
         if (cmd_valid && !bus_w.cmd_ready) stall_cnt++;
         if (bus_w.rsp_valid && rsp_ready) begin
            rsp_w.push_back(bus_w.rsp_payload_outputs_0);
            rsp_cyc.push_back(cyc);
         end
         if (bus_s.rsp_valid && rsp_ready) rsp_s.push_back(bus_s.rsp_payload_outputs_0);
         if (hold_prev && bus_w.rsp_valid && (bus_w.rsp_payload_outputs_0 !== held)) unstable++;
         hold_prev = bus_w.rsp_valid && !rsp_ready;
         held      = bus_w.rsp_payload_outputs_0;
      end else begin
         hold_prev = 1'b0;
      end
      cyc++;
   end

   task automatic clear_log();
      acc_cyc.delete();
      rsp_cyc.delete();
      rsp_w.delete();
      rsp_s.delete();
      stall_cnt = 0;
      unstable  = 0;
   endtask

   // Offer one command and hold it until accepted (bounded)
   task automatic send(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      logic ok = 1'b0;
      cmd_valid = 1'b1;
      fid       = {op, 3'b101};
      op_a      = a;
      op_b      = b;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = bus_w.cmd_ready;
         @(posedge clk);
         #1;
         n++;
      end
      cmd_valid = 1'b0;
      if (!ok) begin
         total++;
         bad++;
         $display("[TB] FAIL send_timeout: op=%0d accepted=%0b required=1", op, ok);
      end
   endtask

   // Wait for n responses (bounded), then a few more cycles to catch extras
   task automatic wait_rsp(input int n);
      int k = 0;
      while (rsp_w.size() < n && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      total += 6;
      if (bus_w.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid_w: got=%b exp=0", bus_w.rsp_valid); end
      if (bus_s.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid_s: got=%b exp=0", bus_s.rsp_valid); end
      if (bus_w.rsp_payload_outputs_0 !== 32'h0) begin bad++; $display("[TB] FAIL reset_payload_w: got=%h exp=0", bus_w.rsp_payload_outputs_0); end
      if (bus_s.rsp_payload_outputs_0 !== 32'h0) begin bad++; $display("[TB] FAIL reset_payload_s: got=%h exp=0", bus_s.rsp_payload_outputs_0); end
      if (bus_w.cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_cmd_ready_w: got=%b exp=1", bus_w.cmd_ready); end
      if (bus_s.cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_cmd_ready_s: got=%b exp=1", bus_s.cmd_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      logic [31:0] exp_v [2] = '{32'd0, 32'd1032};
      clear_log();
      send(7'd1, 32'd128, 32'd0);
      send(7'd0, 32'h0101_0101, 32'h0202_0202);
      wait_rsp(2);
      total++;
      if (rsp_w.size() != 2) begin bad++; $display("[TB] FAIL basic_count: got=%0d exp=2", rsp_w.size()); end
      for (int i = 0; i < 2; i++) begin
         logic [31:0] gw = (i < rsp_w.size()) ? rsp_w[i] : 'x;
         logic [31:0] gs = (i < rsp_s.size()) ? rsp_s[i] : 'x;
         int lat = (i < rsp_cyc.size() && i < acc_cyc.size()) ? rsp_cyc[i] - acc_cyc[i] : -1;
         total += 3;
         if (gw !== exp_v[i]) begin bad++; $display("[TB] FAIL basic_rsp_w[%0d]: got=%h exp=%h", i, gw, exp_v[i]); end
         if (gs !== exp_v[i]) begin bad++; $display("[TB] FAIL basic_rsp_s[%0d]: got=%h exp=%h", i, gs, exp_v[i]); end
         if (lat != 2) begin bad++; $display("[TB] FAIL basic_latency[%0d]: got=%0d exp=2", i, lat); end
      end
   endtask

   task automatic test_stream();
      send(7'd1, 32'd0, 32'd0);
      wait_rsp(1);
      clear_log();
      for (int i = 0; i < 8; i++) send(7'd0, 32'h0000_0001, 32'h0000_0002);
      wait_rsp(8);
      total += 2;
      if (rsp_w.size() != 8) begin bad++; $display("[TB] FAIL stream_count: got=%0d exp=8", rsp_w.size()); end
      if (stall_cnt != 0) begin bad++; $display("[TB] FAIL stream_no_stall: got=%0d exp=0", stall_cnt); end
      for (int i = 0; i < 8; i++) begin
         logic [31:0] gw = (i < rsp_w.size()) ? rsp_w[i] : 'x;
         logic [31:0] gs = (i < rsp_s.size()) ? rsp_s[i] : 'x;
         int gap = (i < acc_cyc.size()) ? acc_cyc[i] - acc_cyc[0] : -1;
         total += 3;
         if (gw !== 32'(2 * (i + 1))) begin bad++; $display("[TB] FAIL stream_rsp_w[%0d]: got=%h exp=%h", i, gw, 2 * (i + 1)); end
         if (gs !== 32'(2 * (i + 1))) begin bad++; $display("[TB] FAIL stream_rsp_s[%0d]: got=%h exp=%h", i, gs, 2 * (i + 1)); end
         if (gap != i) begin bad++; $display("[TB] FAIL stream_accept_cycle[%0d]: got=%0d exp=%0d", i, gap, i); end
      end
   endtask

   task automatic test_stall();
      send(7'd1, 32'd0, 32'd0);
      wait_rsp(1);
      clear_log();
      fork
         begin
            for (int i = 0; i < 8; i++) send(7'd0, 32'h0000_0001, 32'h0000_0002);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            rsp_ready = 1'b1;
         end
      join
      wait_rsp(8);
      total += 3;
      if (rsp_w.size() != 8) begin bad++; $display("[TB] FAIL stall_count: got=%0d exp=8", rsp_w.size()); end
      if (stall_cnt == 0) begin bad++; $display("[TB] FAIL stall_cmd_ready_drop: got=%0d exp>0", stall_cnt); end
      if (unstable != 0) begin bad++; $display("[TB] FAIL stall_payload_stable: got=%0d exp=0", unstable); end
      for (int i = 0; i < 8; i++) begin
         logic [31:0] gw = (i < rsp_w.size()) ? rsp_w[i] : 'x;
         total++;
         if (gw !== 32'(2 * (i + 1))) begin bad++; $display("[TB] FAIL stall_rsp_w[%0d]: got=%h exp=%h", i, gw, 2 * (i + 1)); end
      end
   endtask

   task automatic test_bank();
      logic [31:0] exp_v [5] = '{32'd0, 32'd2, 32'd0, 32'd2, 32'd0};
      send(7'd1, 32'd0, 32'd0);
      wait_rsp(1);
      clear_log();
      send(7'd2, 32'd2, 32'd0);
      send(7'd0, 32'h0000_0001, 32'h0000_0002);
      send(7'd2, 32'd0, 32'd0);
      send(7'd3, 32'd2, 32'd0);
      send(7'd3, 32'd2, 32'd0);
      wait_rsp(5);
      total++;
      if (rsp_w.size() != 5) begin bad++; $display("[TB] FAIL bank_count: got=%0d exp=5", rsp_w.size()); end
      for (int i = 0; i < 5; i++) begin
         logic [31:0] gw = (i < rsp_w.size()) ? rsp_w[i] : 'x;
         total++;
         if (gw !== exp_v[i]) begin bad++; $display("[TB] FAIL bank_rsp_w[%0d]: got=%h exp=%h", i, gw, exp_v[i]); end
      end
   endtask

   task automatic test_offsets();
      logic [31:0] exp_v [4] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_0010};
      clear_log();
      send(7'd1, 32'd128, 32'd0);
      send(7'd0, 32'h8080_8080, 32'h7F7F_7F7F);
      send(7'd1, 32'h0000_FFFF, 32'h0000_FFFE);
      send(7'd0, 32'h7F7F_7F7F, 32'h8080_8080);
      wait_rsp(4);
      total++;
      if (rsp_w.size() != 4) begin bad++; $display("[TB] FAIL offsets_count: got=%0d exp=4", rsp_w.size()); end
      for (int i = 0; i < 4; i++) begin
         logic [31:0] gw = (i < rsp_w.size()) ? rsp_w[i] : 'x;
         logic [31:0] gs = (i < rsp_s.size()) ? rsp_s[i] : 'x;
         total += 2;
         if (gw !== exp_v[i]) begin bad++; $display("[TB] FAIL offsets_rsp_w[%0d]: got=%h exp=%h", i, gw, exp_v[i]); end
         if (gs !== exp_v[i]) begin bad++; $display("[TB] FAIL offsets_rsp_s[%0d]: got=%h exp=%h", i, gs, exp_v[i]); end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] exp_w [7] = '{32'd0, 32'd0, 32'h7FFF_FF00, 32'h8000_0308, 32'd0, 32'd0, 32'h7FFF_0210};
      logic [31:0] exp_s [7] = '{32'd0, 32'd0, 32'h7FFF_FF00, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'h8000_0000};
      clear_log();
      send(7'd1, 32'd128, 32'd0);
      send(7'd3, 32'd0, 32'h7FFF_FF00);
      send(7'd2, 32'd0, 32'd0);
      send(7'd0, 32'h0101_0101, 32'h0202_0202);
      send(7'd1, 32'd0, 32'd0);
      send(7'd3, 32'd0, 32'h8000_0010);
      send(7'd0, 32'h7F7F_7F7F, 32'h8080_8080);
      wait_rsp(7);
      total++;
      if (rsp_w.size() != 7) begin bad++; $display("[TB] FAIL overflow_count: got=%0d exp=7", rsp_w.size()); end
      for (int i = 0; i < 7; i++) begin
         logic [31:0] gw = (i < rsp_w.size()) ? rsp_w[i] : 'x;
         logic [31:0] gs = (i < rsp_s.size()) ? rsp_s[i] : 'x;
         total += 2;
         if (gw !== exp_w[i]) begin bad++; $display("[TB] FAIL overflow_wrap[%0d]: got=%h exp=%h", i, gw, exp_w[i]); end
         if (gs !== exp_s[i]) begin bad++; $display("[TB] FAIL overflow_sat[%0d]: got=%h exp=%h", i, gs, exp_s[i]); end
      end
   endtask

   task automatic test_reset_inflight();
      logic [31:0] exp_v [7] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd5};
      clear_log();
      rsp_ready = 1'b0;
      send(7'd0, 32'h0101_0101, 32'h0202_0202);
      send(7'd0, 32'h0101_0101, 32'h0202_0202);
      reset     = 1'b1;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      total += 2;
      if (bus_w.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL inflight_rsp_valid_w: got=%b exp=0", bus_w.rsp_valid); end
      if (bus_s.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL inflight_rsp_valid_s: got=%b exp=0", bus_s.rsp_valid); end
      @(posedge clk);
      #1;
      wait_rsp(0);
      total++;
      if (rsp_w.size() != 0) begin bad++; $display("[TB] FAIL inflight_no_rsp: got=%0d exp=0", rsp_w.size()); end
      clear_log();
      for (int i = 0; i < 4; i++) send(7'd3, 32'(i), 32'd0);
      send(7'd3, 32'd1, 32'd5);
      send(7'h55, 32'd1, 32'd9);
      send(7'd3, 32'd1, 32'd0);
      wait_rsp(7);
      total++;
      if (rsp_w.size() != 7) begin bad++; $display("[TB] FAIL inflight_count: got=%0d exp=7", rsp_w.size()); end
      for (int i = 0; i < 7; i++) begin
         logic [31:0] gw = (i < rsp_w.size()) ? rsp_w[i] : 'x;
         total++;
         if (gw !== exp_v[i]) begin bad++; $display("[TB] FAIL inflight_rsp_w[%0d]: got=%h exp=%h", i, gw, exp_v[i]); end
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      $display("[TB] start");
      test_reset();
      test_basic();
      test_stream();
      test_stall();
      test_bank();
      test_offsets();
      test_overflow();
      test_reset_inflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
